// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALTED} state_e;

  typedef enum logic [2:0] {ACT_HALT, ACT_RET, ACT_CALL, ACT_JMP, ACT_BR, ACT_INC} act_e;

  // One action per RUN cycle: halt > ret > call > jump > branch > increment.
  function automatic act_e sel_action(input logic halt, input logic ret,
                                      input logic call, input logic jump,
                                      input logic br);
    if (halt)      return ACT_HALT;
    else if (ret)  return ACT_RET;
    else if (call) return ACT_CALL;
    else if (jump) return ACT_JMP;
    else if (br)   return ACT_BR;
    else           return ACT_INC;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and fetch-address outputs of the sequencer.
// The performance counters exist only when PC_PERF_EN is defined.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 9,
  parameter int IDX_W = 2
);
  logic             init;
  logic             halt;
  logic             branch_en;
  logic             bSIGN;
  logic [OFF_W-1:0] bOFFSET;
  logic             jump_en;
  logic             call_en;
  logic             ret_en;
  logic [PC_W-1:0]  jump_addr;
  logic [PC_W-1:0]  PC;
  logic [IDX_W-1:0] prog_idx;
  logic             running;
  logic             done;
  logic             ras_err;
`ifdef PC_PERF_EN
  logic [31:0]      cyc_cnt;
  logic [31:0]      taken_cnt;
`endif

  // Controller side: drives control, observes the fetch address.
  modport master (
    output init, halt, branch_en, bSIGN, bOFFSET, jump_en, call_en, ret_en, jump_addr,
`ifdef PC_PERF_EN
    input  cyc_cnt, taken_cnt,
`endif
    input  PC, prog_idx, running, done, ras_err
  );

  // Sequencer side.
  modport slave (
    input  init, halt, branch_en, bSIGN, bOFFSET, jump_en, call_en, ret_en, jump_addr,
`ifdef PC_PERF_EN
    output cyc_cnt, taken_cnt,
`endif
    output PC, prog_idx, running, done, ras_err
  );

endinterface

// File: rtl/pc_ras.sv
// pc_ras: small return-address stack; clr empties it in one cycle.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] sp_q, sp_d;

  assign full  = (sp_q == CW'(DEPTH));
  assign empty = (sp_q == '0);
  assign top   = mem_q[AW'(sp_q - CW'(1))];

  // Stack pointer update: clear beats push/pop; over/underflow is ignored here.
  always_comb begin
    sp_d = sp_q;
    if (clr)                sp_d = '0;
    else if (push && !full) sp_d = sp_q + CW'(1);
    else if (pop && !empty) sp_d = sp_q - CW'(1);
  end

  // Only the pointer is reset; entry contents are don't-care while unused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // Write the pushed return address into the next free slot.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem_q[sp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC with program select, branches, jumps, call/return
// and a halted state. Define PC_PERF_EN to add cyc_cnt/taken_cnt counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                          PC_W      = 10,
  parameter int                          OFF_W     = 9,
  parameter int                          NUM_PROGS = 3,
  parameter logic [NUM_PROGS*PC_W-1:0]   PROG_BASE = {10'd220, 10'd219, 10'd0},
  parameter int                          RAS_DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  pc_sequencer_if.slave  bus
);
  localparam int IDX_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              init_q, init_d;
  logic              first_load_q, first_load_d;
  logic              ras_err_q, ras_err_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  logic              ras_push, ras_pop, ras_clr;
  logic              ras_full, ras_empty;
  logic [PC_W-1:0]   ras_top, pc_inc, br_off;
  act_e              act;

  assign pc_inc = pc_q + PC_W'(1);
  assign br_off = PC_W'(bus.bOFFSET);
  assign act    = sel_action(bus.halt, bus.ret_en, bus.call_en, bus.jump_en, bus.branch_en);

  pc_ras #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (ras_push),
    .pop   (ras_pop),
    .clr   (ras_clr),
    .din   (pc_inc),
    .top   (ras_top),
    .full  (ras_full),
    .empty (ras_empty)
  );

  // Next-state, next-PC and RAS control; init overrides every state and action.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    idx_d        = idx_q;
    first_load_d = first_load_q;
    ras_err_d    = ras_err_q;
    init_d       = bus.init;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    ras_clr      = 1'b0;
    if (bus.init) begin
      state_d   = LOAD;
      ras_clr   = 1'b1;
      ras_err_d = 1'b0;
      if (!init_q) begin
        if (first_load_q)                          first_load_d = 1'b0;
        else if (idx_q != IDX_W'(NUM_PROGS - 1))   idx_d = idx_q + IDX_W'(1);
      end
      pc_d = PROG_BASE[int'(idx_d)*PC_W +: PC_W];
    end else begin
      case (state_q)
        LOAD: state_d = RUN;
        RUN: begin
          case (act)
            ACT_HALT: state_d = HALTED;
            ACT_RET: begin
              if (ras_empty) begin
                ras_err_d = 1'b1;
                pc_d      = pc_inc;
              end else begin
                ras_pop = 1'b1;
                pc_d    = ras_top;
              end
            end
            ACT_CALL: begin
              if (ras_full) ras_err_d = 1'b1;
              else          ras_push  = 1'b1;
              pc_d = bus.jump_addr;
            end
            ACT_JMP: pc_d = bus.jump_addr;
            ACT_BR:  pc_d = bus.bSIGN ? (pc_q - br_off) : (pc_q + br_off);
            default: pc_d = pc_inc;
          endcase
        end
        default: ;
      endcase
    end
    running_d = (state_d == RUN);
    done_d    = (state_d == HALTED);
  end

  // Sequencer state registers; outputs are registered copies of the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      pc_q         <= PROG_BASE[PC_W-1:0];
      idx_q        <= '0;
      init_q       <= 1'b0;
      first_load_q <= 1'b1;
      ras_err_q    <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      init_q       <= init_d;
      first_load_q <= first_load_d;
      ras_err_q    <= ras_err_d;
      running_q    <= running_d;
      done_q       <= done_d;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.prog_idx = idx_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.ras_err  = ras_err_q;

`ifdef PC_PERF_EN
  logic [31:0] cyc_q, cyc_d, taken_q, taken_d;
  logic        taken;

  // Flow change: any ret that actually pops, any call/jump/branch.
  assign taken = (state_q == RUN) &&
                 ((act == ACT_RET && !ras_empty) || act == ACT_CALL ||
                  act == ACT_JMP || act == ACT_BR);

  // Saturating counters, cleared on entry to LOAD.
  always_comb begin
    cyc_d   = cyc_q;
    taken_d = taken_q;
    if (bus.init) begin
      cyc_d   = '0;
      taken_d = '0;
    end else begin
      if (state_q == RUN && cyc_q != '1)   cyc_d   = cyc_q + 32'd1;
      if (taken && taken_q != '1)          taken_d = taken_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cyc_q   <= '0;
      taken_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      taken_q <= taken_d;
    end
  end

  assign bus.cyc_cnt   = cyc_q;
  assign bus.taken_cnt = taken_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with hand-computed expectations.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(10), .OFF_W(9), .IDX_W(2)) sif ();

  pc_sequencer #(
    .PC_W(10), .OFF_W(9), .NUM_PROGS(3),
    .PROG_BASE({10'd220, 10'd219, 10'd0}), .RAS_DEPTH(4)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (sif)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctrl();
    sif.init = 0; sif.halt = 0; sif.branch_en = 0; sif.bSIGN = 0; sif.bOFFSET = '0;
    sif.jump_en = 0; sif.call_en = 0; sif.ret_en = 0; sif.jump_addr = '0;
  endtask

  task automatic do_jump(input logic [9:0] a);
    clr_ctrl(); sif.jump_en = 1; sif.jump_addr = a; tick(); clr_ctrl();
  endtask

  task automatic do_branch(input logic s, input logic [8:0] off);
    clr_ctrl(); sif.branch_en = 1; sif.bSIGN = s; sif.bOFFSET = off; tick(); clr_ctrl();
  endtask

  task automatic init_pulse();
    clr_ctrl(); sif.init = 1; tick(); tick(); sif.init = 0;
  endtask

  initial begin
    clr_ctrl();
    #3;
    check_eq("rst_pc", sif.PC, 0);
    check_eq("rst_idx", sif.prog_idx, 0);
    check_eq("rst_running", sif.running, 0);
    check_eq("rst_done", sif.done, 0);
    check_eq("rst_ras_err", sif.ras_err, 0);
    tick();
    rst_n = 1;

    // program selection
    init_pulse();
    check_eq("load1_pc", sif.PC, 0);
    check_eq("load1_idx", sif.prog_idx, 0);
    tick();
    init_pulse();
    check_eq("load2_pc", sif.PC, 219);
    check_eq("load2_idx", sif.prog_idx, 1);
    tick();
    init_pulse();
    check_eq("load3_pc", sif.PC, 220);
    tick();
    init_pulse();
    check_eq("load4_pc", sif.PC, 220);
    check_eq("load4_idx", sif.prog_idx, 2);
    tick();
    check_eq("run_first_fetch", sif.PC, 220);
    check_eq("run_flag", sif.running, 1);
    tick();
    check_eq("run_inc", sif.PC, 221);

    // branches and wrap
    do_jump(100);
    check_eq("jump_pc", sif.PC, 100);
    do_branch(0, 5);
    check_eq("br_fwd", sif.PC, 105);
    do_branch(1, 10);
    check_eq("br_back", sif.PC, 95);
    do_jump(1020);
    do_branch(0, 8);
    check_eq("br_wrap", sif.PC, 4);
    do_jump(1023);
    tick();
    check_eq("inc_wrap", sif.PC, 0);

    // call / return
    do_jump(50);
    sif.call_en = 1; sif.jump_addr = 300; tick(); clr_ctrl();
    check_eq("call_pc", sif.PC, 300);
    tick(); tick();
    check_eq("call_body", sif.PC, 302);
    sif.ret_en = 1; tick(); clr_ctrl();
    check_eq("ret_pc", sif.PC, 51);
    check_eq("ret_no_err", sif.ras_err, 0);
    for (int i = 0; i < 4; i++) begin
      sif.call_en = 1; sif.jump_addr = 10'(500 + i); tick(); clr_ctrl();
    end
    check_eq("call4_no_err", sif.ras_err, 0);
    sif.call_en = 1; sif.jump_addr = 504; tick(); clr_ctrl();
    check_eq("call5_err", sif.ras_err, 1);
    check_eq("call5_pc", sif.PC, 504);
    sif.ret_en = 1; tick();
    check_eq("ret1_pc", sif.PC, 503);
    tick(); tick(); tick();
    check_eq("ret4_pc", sif.PC, 52);
    tick(); clr_ctrl();
    check_eq("ret5_pc", sif.PC, 53);
    check_eq("ret5_err", sif.ras_err, 1);

    // halt
    do_jump(40);
    sif.halt = 1; sif.branch_en = 1; sif.bOFFSET = 7; sif.call_en = 1; sif.jump_addr = 600;
    tick(); clr_ctrl();
    check_eq("halt_pc", sif.PC, 40);
    check_eq("halt_done", sif.done, 1);
    check_eq("halt_running", sif.running, 0);
    do_branch(0, 9);
    check_eq("halt_ignore_br", sif.PC, 40);
    sif.init = 1; tick();
    check_eq("halt_init_done", sif.done, 0);
    check_eq("halt_init_err", sif.ras_err, 0);
    check_eq("halt_init_pc", sif.PC, 220);
    sif.init = 0; tick();

    // asynchronous reset mid-cycle
    do_jump(77);
    check_eq("pre_rst_pc", sif.PC, 77);
    #2; rst_n = 0; #1;
    check_eq("async_rst_pc", sif.PC, 0);
    check_eq("async_rst_idx", sif.prog_idx, 0);
    check_eq("async_rst_running", sif.running, 0);
    tick();
    rst_n = 1;

`ifdef PC_PERF_EN
    init_pulse();
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 7) begin
        sif.branch_en = 1; sif.bOFFSET = 3;
      end
      tick(); clr_ctrl();
    end
    check_eq("perf_cyc", sif.cyc_cnt, 10);
    check_eq("perf_taken", sif.taken_cnt, 3);
    sif.init = 1; tick(); sif.init = 0;
    check_eq("perf_cyc_clr", sif.cyc_cnt, 0);
    check_eq("perf_taken_clr", sif.taken_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer that supersedes the single-program fetch PC. It supports N selectable program entry points, sign-magnitude relative branches, absolute jumps, and call/return through a small return-address stack (RAS). It also has an explicit HALTED state with a done flag. It sits at the head of the fetch stage and drives the instruction-ROM address.

Parameters:
PC_W, 10, PC / instruction-address width
OFF_W, 9, branch offset magnitude width (OFF_W <= PC_W)
NUM_PROGS, 3, number of program entry points
PROG_BASE, {10'd220,10'd219,10'd0}, packed NUM_PROGS*PC_W entry table; entry k at bits [k*PC_W +: PC_W]
RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2)

Ports:
CLK  in  1  clock, posedge
RST_N  in  1  asynchronous active-low reset
init  in  1  level; load/hold program entry point
halt  in  1  stop fetching (RUN only)
branch_en  in  1  relative branch
bSIGN  in  1  1 = PC - bOFFSET, 0 = PC + bOFFSET
bOFFSET  in  OFF_W  branch magnitude, unsigned
jump_en  in  1  absolute jump to jump_addr
call_en  in  1  push PC+1, go to jump_addr
ret_en  in  1  pop RAS into PC
jump_addr  in  PC_W  target for jump/call
PC  out  PC_W  current fetch address
prog_idx  out  $clog2(NUM_PROGS)  selected program
running  out  1  state == RUN
done  out  1  state == HALTED
ras_err  out  1  sticky RAS overflow/underflow

Behaviour:
- Reset (async, RST_N=0): state=IDLE, PC=PROG_BASE[0], prog_idx=0, RAS empty, ras_err=0, first_load=1.
- States: IDLE, LOAD, RUN, HALTED. All updates occur on posedge CLK.
- init=1 in any state -> next state LOAD.
  - On the first cycle of each init assertion (rising edge seen vs a registered init_q), prog_idx advances.
  - Exception: the first load after reset keeps prog_idx=0 and clears first_load.
  - prog_idx saturates at NUM_PROGS-1.
  - PC <= PROG_BASE[next prog_idx] every LOAD cycle. RAS is cleared; ras_err is cleared.
- LOAD with init=0 -> RUN. PC keeps the loaded base; first fetch is at the base address.
- IDLE with init=0: hold.
- RUN, one action per cycle, priority halt > ret > call > jump > branch > increment:
  - halt: -> HALTED, PC holds.
  - ret: RAS non-empty -> PC <= top, pop. RAS empty -> ras_err<=1, PC <= PC+1.
  - call: RAS not full -> push PC+1, PC <= jump_addr. RAS full -> ras_err<=1, no push, PC <= jump_addr.
  - jump: PC <= jump_addr.
  - branch: PC <= PC +/- zero-extended bOFFSET.
  - none: PC <= PC+1.
- Arithmetic is modulo 2^PC_W; wrap-around is silent, with no error (PC=1023, +1 -> 0).
- HALTED: PC, RAS and prog_idx hold. Control inputs are ignored except init.
- Simultaneous init and anything else: init wins.
- Reset mid-operation: immediate return to reset values, independent of CLK.
- Latency: a control input sampled at edge k is reflected on PC after edge k; PC is registered, with no combinational input->PC path.

Optional Feature:
PC_PERF_EN
- Defined: adds outputs cyc_cnt[31:0] and taken_cnt[31:0].
  - cyc_cnt counts RUN cycles.
  - taken_cnt counts cycles where ret/call/jump/branch changes flow.
  - Both are cleared on reset and on entry to LOAD, and saturate at all-ones.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Package pc_seq_pkg: state enum (IDLE, LOAD, RUN, HALTED) and a priority action enum (ACT_HALT, ACT_RET, ACT_CALL, ACT_JMP, ACT_BR, ACT_INC).
- Sub-module pc_ras: parametrised by depth/width.
  - Inputs: push, pop, clr, din. Outputs: top, full, empty.
  - Async active-low reset; push and pop never both asserted by the parent.

Test Plan:
- Reset then init pulse (2 cycles) -> PC=0, prog_idx=0. Second pulse -> PC=219, prog_idx=1. Third -> PC=220. Fourth -> stays 220, prog_idx=2.
- RUN from PC=100: branch bSIGN=0 bOFFSET=5 -> 105. Then bSIGN=1 bOFFSET=10 -> 95. PC=1020 plus bOFFSET=8 -> 4 (wrap).
- Call jump_addr=300 from PC=50 -> PC=300. Idle 2 cycles -> 302. ret -> 51. A 5th nested call with RAS_DEPTH=4 -> ras_err=1, PC=jump_addr. A 5th ret -> ras_err stays 1, PC+1.
- Same-cycle halt+branch+call at PC=40 -> HALTED, PC=40, done=1. Further branches are ignored. Then init -> LOAD, done=0, ras_err=0.
- Drop RST_N mid-cycle while PC=77 in RUN -> PC=0, state IDLE, prog_idx=0 before the next CLK edge.
- With PC_PERF_EN: 10 RUN cycles including 3 branches -> cyc_cnt=10, taken_cnt=3. Then init -> both 0.
